mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access (MEM) stage of the vector/scalar encryption pipeline. It consumes the registered EX/MEM bundle and serialises scalar and vector loads and stores into per-element beats on the single-port, element-wide data memory. It stalls upstream while a multi-beat access is in flight. It presents a registered MEM/WB bundle with a valid strobe to write-back.

## Interface
- REGI_SIZE, 16: scalar register width
- ELEM_SIZE, 8: vector element width and data-memory word width
- VECT_SIZE, 8: elements per vector
- MEMO_LINES, 64: data-memory depth in words; AW = $clog2(MEMO_LINES)
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- ialu_res_i  in  REGI_SIZE  memory address (mem ops) or scalar ALU result
- valu_res_i  in  ELEM_SIZE*VECT_SIZE  store data (mem writes) or vector ALU result
- enableMem_i, enableReg_i, enableJump_i  in  1  stage enables from EX/MEM
- flagMemRead_i, flagMemWrite_i  in  1  load / store request
- isOper2Int_i  in  1  store is scalar (REGI_SIZE bits); else vector
- writeResultInt_i, writeResultV_i  in  1  load/result destination class
- alu_flags_i  in  4  ALU flags
- stall_o  out  1  upstream must hold its bundle
- mem_addr_o  out  AW  data-memory address
- mem_wdata_o  out  ELEM_SIZE  write data
- mem_we_o  out  1  write enable
- mem_rdata_i  in  ELEM_SIZE  synchronous read data (1-cycle latency)
- wb_valid_o  out  1  MEM/WB bundle valid
- ialu_res_o, valu_res_o, enableReg_o, enableJump_o, writeResultInt_o, writeResultV_o, alu_flags_o  out  as inputs  MEM/WB bundle

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- A memory op starts in IDLE when enableMem_i & (flagMemRead_i | flagMemWrite_i). The start cycle T latches base, data, kind and beats. No memory access happens in T. Next state is ISSUE.
- If read and write are both set, the op is a load. No write is issued.
- Beats: N = VECT_SIZE for vector ops, REGI_SIZE/ELEM_SIZE for scalar ops.
  - Scalar/vector for loads: writeResultInt_i=1 means scalar.
  - Scalar/vector for stores: isOper2Int_i=1 means scalar.
- Beat k is at address (base + k) mod MEMO_LINES, where base = ialu_res_i[AW-1:0]. Addresses wrap from MEMO_LINES-1 to 0.
- Element k occupies bits [k*ELEM_SIZE +: ELEM_SIZE]. The same mapping holds for scalar bytes (little-endian).
- ISSUE runs N cycles with mem_addr_o = base+k, k = 0..N-1.
  - Store: mem_we_o=1 and mem_wdata_o = element k. Exit to IDLE.
  - Load: mem_we_o=0. Read data for beat k is captured the following cycle. Exit to DRAIN.
- DRAIN (loads only) lasts 1 cycle and captures the last beat. Next state is IDLE.
- Load results go to a zero-filled register: a scalar load returns on ialu_res_o, a vector load on valu_res_o.
- Non-memory bundles (enableMem_i=0) pass straight through the output register.
- Bubble input (enableReg_i=0, enableMem_i=0) gives wb_valid_o=0.

## Timing
- stall_o = (state != IDLE) | start. This is combinational and high from T through the last busy cycle.
- Inputs are ignored while state != IDLE.
- Pass-through op: registered, wb_valid_o at T+1, no stall.
- Store: writes in T+1..T+N. wb_valid_o=1 with enableReg_o=0 at T+N+1, which is also the next accept cycle.
- Load: reads issued T+1..T+N, DRAIN at T+N+1. wb_valid_o=1 with result at T+N+2, which is also the next accept cycle.
- wb_valid_o=0 in every cycle between T+1 and completion.
- Reset:
  - All outputs are 0, state is IDLE, mem_we_o=0, mem_addr_o=0.
  - Reset mid-op aborts with no further writes in the next cycle. Already-written beats remain in memory.
- No back-pressure from write-back. Output holds exactly one cycle per valid.

## Structure
- Package mem_stage_pkg holds:
  - the state enum (IDLE/ISSUE/DRAIN);
  - a function computing AW and beat count from the parameters;
  - localparam SCALAR_BEATS = REGI_SIZE/ELEM_SIZE.
- No sub-module needed. Keep the beat counter, address adder, load assembly register and output register in one module.

## Test plan
- Pass-through: ialu_res_i=16'h1234, enableReg_i=1, enableMem_i=0 -> at T+1, wb_valid_o=1, ialu_res_o=16'h1234, stall_o never high.
- Vector store: base 6'd4, valu_res_i=64'h0807060504030201 -> writes 01..08 to addresses 4..11 in T+1..T+8, wb_valid_o at T+9, stall_o high T..T+8.
- Vector load, wrap: memory [62,63,0..5] preloaded with 0xA0..0xA7, base 62 -> at T+10, valu_res_o=64'hA7A6A5A4A3A2A1A0, wb_valid_o=1.
- Scalar store/load: store 16'hBEEF at 10, then load from 10 -> bytes EF@10, BE@11; load returns ialu_res_o=16'hBEEF after 4 cycles.
- Read+write both set -> behaves as load; mem_we_o never asserted.
- Reset at beat 3 of a vector store -> mem_we_o=0 next cycle, all outputs 0, stall_o=0; addresses base..base+2 hold written data.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// mem_stage_pkg : shared types and sizing helpers for the MEM pipeline stage
// Revision      : 1.0
// ============================================================================
package mem_stage_pkg;

  localparam int DEF_REGI_SIZE  = 16;
  localparam int DEF_ELEM_SIZE  = 8;
  localparam int DEF_VECT_SIZE  = 8;
  localparam int DEF_MEMO_LINES = 64;
  localparam int SCALAR_BEATS   = DEF_REGI_SIZE / DEF_ELEM_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Side-band fields carried alongside the data through MEM/WB
  typedef struct packed {
    logic       en_reg;
    logic       en_jump;
    logic       wr_int;
    logic       wr_v;
    logic [3:0] flags;
  } wb_meta_t;

  function automatic int calc_aw(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

  function automatic int calc_beats(input logic is_scalar, input int regi,
                                    input int elem, input int vect);
    return is_scalar ? (regi / elem) : vect;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// mem_access_stage : serialises scalar/vector loads and stores into per-element
//                    beats on a single-port data memory; registered MEM/WB out
// Revision         : 1.0
// ============================================================================
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int REGI_SIZE  = DEF_REGI_SIZE,
  parameter int ELEM_SIZE  = DEF_ELEM_SIZE,
  parameter int VECT_SIZE  = DEF_VECT_SIZE,
  parameter int MEMO_LINES = DEF_MEMO_LINES
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [REGI_SIZE-1:0]           ialu_res_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_i,
  input  logic                           enableMem_i,
  input  logic                           enableReg_i,
  input  logic                           enableJump_i,
  input  logic                           flagMemRead_i,
  input  logic                           flagMemWrite_i,
  input  logic                           isOper2Int_i,
  input  logic                           writeResultInt_i,
  input  logic                           writeResultV_i,
  input  logic [3:0]                     alu_flags_i,
  output logic                           stall_o,
  output logic [calc_aw(MEMO_LINES)-1:0] mem_addr_o,
  output logic [ELEM_SIZE-1:0]           mem_wdata_o,
  output logic                           mem_we_o,
  input  logic [ELEM_SIZE-1:0]           mem_rdata_i,
  output logic                           wb_valid_o,
  output logic [REGI_SIZE-1:0]           ialu_res_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_o,
  output logic                           enableReg_o,
  output logic                           enableJump_o,
  output logic                           writeResultInt_o,
  output logic                           writeResultV_o,
  output logic [3:0]                     alu_flags_o
);

  localparam int AW   = calc_aw(MEMO_LINES);
  localparam int VW   = ELEM_SIZE * VECT_SIZE;
  localparam int MAXB = (VECT_SIZE > REGI_SIZE / ELEM_SIZE) ? VECT_SIZE : REGI_SIZE / ELEM_SIZE;
  localparam int CW   = $clog2(MAXB + 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     base_q, base_d;
  logic [VW-1:0]     data_q, data_d;
  logic              is_load_q, is_load_d;
  logic              scal_q, scal_d;
  logic [CW-1:0]     beats_q, beats_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [CW-1:0]     rd_idx_q, rd_idx_d;
  logic [VW-1:0]     ld_q, ld_d;
  wb_meta_t          lat_meta_q, lat_meta_d;

  logic              wb_valid_q, wb_valid_d;
  logic [REGI_SIZE-1:0] ialu_q, ialu_d;
  logic [VW-1:0]     valu_q, valu_d;
  wb_meta_t          meta_q, meta_d;

  logic start;
  logic start_scalar;
  logic last_beat;

  assign start        = (state_q == ST_IDLE) & enableMem_i & (flagMemRead_i | flagMemWrite_i);
  // A read request wins over a simultaneous write request
  assign start_scalar = flagMemRead_i ? writeResultInt_i : isOper2Int_i;
  assign last_beat    = (cnt_q == beats_q - CW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: if (last_beat) state_d = is_load_q ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    stall_o     = (state_q != ST_IDLE) | start;
    if (state_q == ST_ISSUE) begin
      mem_addr_o  = base_q + AW'(cnt_q);
      mem_we_o    = ~is_load_q;
      mem_wdata_o = is_load_q ? '0 : data_q[int'(cnt_q)*ELEM_SIZE +: ELEM_SIZE];
    end
  end

  always_comb begin
    base_d     = base_q;
    data_d     = data_q;
    is_load_d  = is_load_q;
    scal_d     = scal_q;
    beats_d    = beats_q;
    cnt_d      = cnt_q;
    rd_pend_d  = 1'b0;
    rd_idx_d   = rd_idx_q;
    lat_meta_d = lat_meta_q;
    ld_d       = ld_q;
    wb_valid_d = 1'b0;
    ialu_d     = ialu_q;
    valu_d     = valu_q;
    meta_d     = meta_q;

    // Read data arrives one cycle after its beat was issued
    if (rd_pend_q) ld_d[int'(rd_idx_q)*ELEM_SIZE +: ELEM_SIZE] = mem_rdata_i;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = ialu_res_i[AW-1:0];
          data_d     = valu_res_i;
          is_load_d  = flagMemRead_i;
          scal_d     = start_scalar;
          beats_d    = CW'(calc_beats(start_scalar, REGI_SIZE, ELEM_SIZE, VECT_SIZE));
          cnt_d      = '0;
          ld_d       = '0;
          lat_meta_d = '{en_reg: enableReg_i, en_jump: enableJump_i, wr_int: writeResultInt_i,
                         wr_v: writeResultV_i, flags: alu_flags_i};
        end else begin
          wb_valid_d = enableReg_i | enableMem_i;
          ialu_d     = ialu_res_i;
          valu_d     = valu_res_i;
          meta_d     = '{en_reg: enableReg_i, en_jump: enableJump_i, wr_int: writeResultInt_i,
                         wr_v: writeResultV_i, flags: alu_flags_i};
        end
      end
      ST_ISSUE: begin
        cnt_d     = cnt_q + CW'(1);
        rd_pend_d = is_load_q;
        rd_idx_d  = cnt_q;
        if (last_beat && !is_load_q) begin
          wb_valid_d    = 1'b1;
          meta_d        = lat_meta_q;
          meta_d.en_reg = 1'b0;
          ialu_d        = '0;
          valu_d        = data_q;
        end
      end
      ST_DRAIN: begin
        wb_valid_d = 1'b1;
        meta_d     = lat_meta_q;
        ialu_d     = scal_q ? ld_d[REGI_SIZE-1:0] : '0;
        valu_d     = scal_q ? '0 : ld_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q     <= '0;
      data_q     <= '0;
      is_load_q  <= 1'b0;
      scal_q     <= 1'b0;
      beats_q    <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
      ld_q       <= '0;
      lat_meta_q <= '0;
      wb_valid_q <= 1'b0;
      ialu_q     <= '0;
      valu_q     <= '0;
      meta_q     <= '0;
    end else begin
      base_q     <= base_d;
      data_q     <= data_d;
      is_load_q  <= is_load_d;
      scal_q     <= scal_d;
      beats_q    <= beats_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_idx_q   <= rd_idx_d;
      ld_q       <= ld_d;
      lat_meta_q <= lat_meta_d;
      wb_valid_q <= wb_valid_d;
      ialu_q     <= ialu_d;
      valu_q     <= valu_d;
      meta_q     <= meta_d;
    end
  end

  assign wb_valid_o       = wb_valid_q;
  assign ialu_res_o       = ialu_q;
  assign valu_res_o       = valu_q;
  assign enableReg_o      = meta_q.en_reg;
  assign enableJump_o     = meta_q.en_jump;
  assign writeResultInt_o = meta_q.wr_int;
  assign writeResultV_o   = meta_q.wr_v;
  assign alu_flags_o      = meta_q.flags;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_access_stage : scoreboard bench with a byte-array reference model
// Revision            : 1.0
// ============================================================================
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] ialu_res_i;
  logic [63:0] valu_res_i;
  logic        enableMem_i, enableReg_i, enableJump_i;
  logic        flagMemRead_i, flagMemWrite_i, isOper2Int_i;
  logic        writeResultInt_i, writeResultV_i;
  logic [3:0]  alu_flags_i;
  logic        stall_o;
  logic [5:0]  mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_we_o;
  logic [7:0]  mem_rdata;
  logic        wb_valid_o;
  logic [15:0] ialu_res_o;
  logic [63:0] valu_res_o;
  logic        enableReg_o, enableJump_o, writeResultInt_o, writeResultV_o;
  logic [3:0]  alu_flags_o;

  mem_access_stage dut (
    .clk_i(clk), .rst_i(rst_i),
    .ialu_res_i(ialu_res_i), .valu_res_i(valu_res_i),
    .enableMem_i(enableMem_i), .enableReg_i(enableReg_i), .enableJump_i(enableJump_i),
    .flagMemRead_i(flagMemRead_i), .flagMemWrite_i(flagMemWrite_i),
    .isOper2Int_i(isOper2Int_i), .writeResultInt_i(writeResultInt_i),
    .writeResultV_i(writeResultV_i), .alu_flags_i(alu_flags_i),
    .stall_o(stall_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata),
    .wb_valid_o(wb_valid_o), .ialu_res_o(ialu_res_o), .valu_res_o(valu_res_o),
    .enableReg_o(enableReg_o), .enableJump_o(enableJump_o),
    .writeResultInt_o(writeResultInt_o), .writeResultV_o(writeResultV_o),
    .alu_flags_o(alu_flags_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory seen by the DUT, with a preload port used during reset
  logic [7:0] tb_mem [64];
  logic       init_we = 1'b0;
  logic [5:0] init_addr = '0;
  logic [7:0] init_data = '0;
  always @(posedge clk) begin
    if (init_we) tb_mem[init_addr] <= init_data;
    else if (mem_we_o === 1'b1) tb_mem[mem_addr_o] <= mem_wdata_o;
    mem_rdata <= tb_mem[mem_addr_o];
  end

  logic [7:0] ref_mem [64];

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int next_free = 0;

  typedef struct { int cyc; logic en_reg; bit chk_i; logic [15:0] ialu; bit chk_v; logic [63:0] valu; } wb_exp_t;
  typedef struct { int cyc; logic [5:0] addr; logic [7:0] data; } wr_exp_t;
  wb_exp_t wbq[$];
  wr_exp_t wrq[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_exp_t x;
    wb_exp_t w;
    if (mon_en) begin
      if (mem_we_o === 1'b1) begin
        if (wrq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: addr %0d data %h, none expected", mem_addr_o, mem_wdata_o);
        end else begin
          x = wrq.pop_front();
          check("wr_addr", 64'(mem_addr_o), 64'(x.addr));
          check("wr_data", 64'(mem_wdata_o), 64'(x.data));
          check("wr_cycle", 64'(cyc), 64'(x.cyc));
        end
      end
      if (wb_valid_o === 1'b1) begin
        if (wbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_wb_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          w = wbq.pop_front();
          check("wb_cycle", 64'(cyc), 64'(w.cyc));
          check("wb_en_reg", 64'(enableReg_o), 64'(w.en_reg));
          if (w.chk_i) check("wb_ialu", 64'(ialu_res_o), 64'(w.ialu));
          if (w.chk_v) check("wb_valu", valu_res_o, w.valu);
        end
      end
    end
  end

  task automatic drive_idle();
    ialu_res_i = '0; valu_res_i = '0;
    enableMem_i = 0; enableReg_i = 0; enableJump_i = 0;
    flagMemRead_i = 0; flagMemWrite_i = 0; isOper2Int_i = 0;
    writeResultInt_i = 0; writeResultV_i = 0; alu_flags_i = '0;
  endtask

  task automatic wait_ready(input int exp_cyc);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; drive_idle(); #1; n++;
    end while (stall_o && n < 40);
    if (stall_o) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: stall_o still high after %0d cycles", n);
    end else check("ready_cycle", 64'(cyc), 64'(exp_cyc));
  endtask

  // kind: 0 = non-memory bundle, 1 = store, 2 = load
  task automatic issue(input int kind, input bit scal, input logic [15:0] ialu,
                       input logic [63:0] data, input bit both, input bit en_reg);
    int t, nb, a;
    logic [63:0] res;
    wb_exp_t w;
    wr_exp_t x;
    wait_ready(next_free);
    t = cyc;
    ialu_res_i = ialu; valu_res_i = data;
    enableReg_i = en_reg; enableJump_i = 1'($urandom); alu_flags_i = 4'($urandom);
    writeResultV_i = 1'($urandom);
    nb = scal ? 2 : 8;
    if (kind == 0) begin
      enableMem_i = 0; flagMemRead_i = 1'($urandom); flagMemWrite_i = 1'($urandom);
      isOper2Int_i = 1'($urandom); writeResultInt_i = 1'($urandom);
      if (en_reg) begin
        w = '{t + 1, 1'b1, 1'b1, ialu, 1'b1, data};
        wbq.push_back(w);
      end
      next_free = t + 1;
    end else if (kind == 1) begin
      enableMem_i = 1; flagMemRead_i = 0; flagMemWrite_i = 1;
      isOper2Int_i = scal; writeResultInt_i = 1'($urandom);
      for (int k = 0; k < nb; k++) begin
        a = (int'(ialu[5:0]) + k) % 64;
        x = '{t + 1 + k, 6'(a), data[k*8 +: 8]};
        wrq.push_back(x);
        ref_mem[a] = data[k*8 +: 8];
      end
      w = '{t + nb + 1, 1'b0, 1'b0, 16'h0, 1'b0, 64'h0};
      wbq.push_back(w);
      next_free = t + nb + 1;
    end else begin
      enableMem_i = 1; flagMemRead_i = 1; flagMemWrite_i = both;
      writeResultInt_i = scal; isOper2Int_i = 1'($urandom);
      res = '0;
      for (int k = 0; k < nb; k++) res[k*8 +: 8] = ref_mem[(int'(ialu[5:0]) + k) % 64];
      w = '{t + nb + 2, en_reg, scal, res[15:0], !scal, res};
      wbq.push_back(w);
      next_free = t + nb + 2;
    end
    #1;
    check("stall_at_accept", 64'(stall_o), 64'(kind != 0));
  endtask

  initial begin
    int t;
    logic [63:0] d;
    logic [15:0] ia;
    logic [7:0] old23;
    int kind;
    rst_i = 1'b1;
    drive_idle();
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      init_we = 1'b1; init_addr = 6'(i);
      init_data = (((i - 62 + 64) % 64) < 8) ? 8'(8'hA0 + (i - 62 + 64) % 64) : 8'($urandom);
      ref_mem[i] = init_data;
    end
    @(posedge clk); #1;
    init_we = 1'b0;
    @(posedge clk); #1;
    check("rst_stall", 64'(stall_o), 64'h0);
    check("rst_we", 64'(mem_we_o), 64'h0);
    check("rst_addr", 64'(mem_addr_o), 64'h0);
    check("rst_wb_valid", 64'(wb_valid_o), 64'h0);
    check("rst_ialu", 64'(ialu_res_o), 64'h0);
    check("rst_valu", valu_res_o, 64'h0);
    check("rst_meta", 64'({enableReg_o, enableJump_o, writeResultInt_o, writeResultV_o, alu_flags_o}), 64'h0);
    rst_i = 1'b0;
    mon_en = 1'b1;
    next_free = cyc + 1;

    issue(0, 0, 16'h1234, 64'h0, 0, 1);
    issue(2, 0, 16'd62, 64'h0, 0, 1);
    issue(1, 0, 16'd4, 64'h0807060504030201, 0, 1);
    issue(1, 1, 16'd10, {$urandom, 16'h0, 16'hBEEF}, 0, 1);
    issue(2, 1, 16'd10, 64'h0, 0, 1);
    issue(2, 0, 16'd30, {$urandom, $urandom}, 1, 1);
    issue(0, 0, 16'hFFFF, 64'h55, 0, 0);
    wait_ready(next_free);
    check("beef_lo", 64'(tb_mem[10]), 64'hEF);
    check("beef_hi", 64'(tb_mem[11]), 64'hBE);
    next_free = cyc + 1;

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      ia = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ia[5:0] = 6'(60 + $urandom_range(0, 3));
      d = {$urandom, $urandom};
      issue(kind, 1'($urandom), ia, d, (kind == 2) && ($urandom_range(0, 3) == 0),
            (kind == 0) ? ($urandom_range(0, 4) != 0) : 1'b1);
    end

    // Abort a vector store by reset just before its fourth beat
    wait_ready(next_free);
    old23 = tb_mem[23];
    d = {$urandom, $urandom};
    t = cyc;
    ialu_res_i = 16'd20; valu_res_i = d;
    enableMem_i = 1; flagMemWrite_i = 1; enableReg_i = 1;
    for (int k = 0; k < 3; k++) wrq.push_back('{t + 1 + k, 6'(20 + k), d[k*8 +: 8]});
    repeat (3) @(posedge clk);
    #1; rst_i = 1'b1; drive_idle();
    @(posedge clk); #1; rst_i = 1'b0; #1;
    check("abort_we", 64'(mem_we_o), 64'h0);
    check("abort_stall", 64'(stall_o), 64'h0);
    check("abort_addr", 64'(mem_addr_o), 64'h0);
    check("abort_wb_valid", 64'(wb_valid_o), 64'h0);
    check("abort_outputs", {ialu_res_o, valu_res_o[47:0]} | 64'(valu_res_o[63:48]), 64'h0);
    @(posedge clk); #2;
    check("abort_mem20", 64'(tb_mem[20]), 64'(d[7:0]));
    check("abort_mem21", 64'(tb_mem[21]), 64'(d[15:8]));
    check("abort_mem22", 64'(tb_mem[22]), 64'(d[23:16]));
    check("abort_mem23_untouched", 64'(tb_mem[23]), 64'(old23));
    repeat (3) @(posedge clk);
    #1;
    check("wr_queue_empty", 64'(wrq.size()), 64'h0);
    check("wb_queue_empty", 64'(wbq.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
